// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine
// SD CMD-line engine: shifts out a 48-bit command with a running CRC7, releases
// the line, then captures an optional short (48-bit) or long (136-bit) response,
// checking start timeout, transmission/end bits, index and CRC7.
// Optional feature macro: SD_CMD_RESP_CRC_CHECK_EN
//   defined   -> receive CRC7 generator/comparator present, ocrc_err reports mismatches
//   undefined -> receive CRC logic omitted, ocrc_err tied low
module sd_cmd_engine #(
  parameter int NCR_MAX = 64,
  parameter int NRC     = 8
) (
  input  logic         iclk,
  input  logic         irst,
  inout  wire          iocmd_sd,
  input  logic         istart,
  input  logic [5:0]   icmd_index,
  input  logic [31:0]  icmd_arg,
  input  logic [1:0]   iresp_type,
  output logic [119:0] oresp,
  output logic         odone,
  output logic         otimeout,
  output logic         ocrc_err,
  output logic         oframe_err
);

  localparam int WW = $clog2(NCR_MAX + 1);
  localparam int GW = $clog2(NRC + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_GAP,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [5:0]     r_index;
  logic [1:0]     r_type;
  logic [39:0]    r_tx_sr;
  logic [6:0]     r_tx_crc;
  logic [5:0]     r_bcnt;
  logic           r_oe;
  logic           r_out;
  logic [WW-1:0]  r_wcnt;
  logic [7:0]     r_rcnt;
  logic [126:0]   r_rx_sr;
  logic           r_rx_tbit;
  logic [GW-1:0]  r_gcnt;
  logic [119:0]   r_resp;
  logic           r_done;
  logic           r_timeout;
  logic           r_frame_err;

  logic           w_line;
  logic           w_long;
  logic [7:0]     w_last;
  logic           w_final;
  logic           w_tx_fb;
  logic           w_idx_bad;
  logic           w_frame_bad;

  // The pad is only ever driven while a command is being shifted out.
  assign iocmd_sd = r_oe ? r_out : 1'bz;
  assign w_line   = iocmd_sd;

  assign w_long      = (r_type == 2'b11);
  assign w_last      = w_long ? 8'd135 : 8'd47;
  assign w_final     = (r_rcnt == w_last);
  assign w_tx_fb     = r_tx_sr[39] ^ r_tx_crc[6];
  // At the final edge r_rx_sr[k] holds frame bit k+1, so the short-frame index
  // field (bits 45..40) sits at [44:39]. R3 and R2 carry no real index.
  assign w_idx_bad   = (r_type == 2'b01) && (r_rx_sr[44:39] != r_index);
  assign w_frame_bad = !w_line || r_rx_tbit || w_idx_bad;

`ifdef SD_CMD_RESP_CRC_CHECK_EN
  logic [6:0] r_rx_crc;
  logic       r_crc_err;
  logic       w_rx_fb;
  logic       w_crc_feed;
  logic       w_crc_bad;

  // Start bit is 0 and the CRC starts at 0, so it is already folded in at entry.
  // Short frames cover bits 46..8, long frames only the payload bits 127..8.
  assign w_rx_fb    = w_line ^ r_rx_crc[6];
  assign w_crc_feed = w_long ? ((r_rcnt >= 8'd8) && (r_rcnt <= 8'd127))
                             : (r_rcnt <= 8'd39);
  assign w_crc_bad  = (r_type != 2'b10) && (r_rx_crc != r_rx_sr[6:0]);
  assign ocrc_err   = r_crc_err;
`else
  assign ocrc_err   = 1'b0;
`endif

  assign oresp      = r_resp;
  assign odone      = r_done;
  assign otimeout   = r_timeout;
  assign oframe_err = r_frame_err;

  // Command/response sequencer: launch, serialise, wait, capture, gap, handshake.
  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_type      <= '0;
      r_tx_sr     <= '0;
      r_tx_crc    <= '0;
      r_bcnt      <= '0;
      r_oe        <= 1'b0;
      r_out       <= 1'b1;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_rx_sr     <= '0;
      r_rx_tbit   <= 1'b0;
      r_gcnt      <= '0;
      r_resp      <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
      r_rx_crc    <= '0;
      r_crc_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (istart) begin
            r_index     <= icmd_index;
            r_type      <= iresp_type;
            r_tx_sr     <= {2'b01, icmd_index, icmd_arg};
            r_tx_crc    <= '0;
            r_bcnt      <= '0;
            r_resp      <= '0;
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            r_crc_err   <= 1'b0;
`endif
            r_state     <= S_SEND;
          end
        end

        S_SEND: begin
          r_bcnt <= r_bcnt + 6'd1;
          if (r_bcnt < 6'd40) begin
            r_oe     <= 1'b1;
            r_out    <= r_tx_sr[39];
            r_tx_sr  <= {r_tx_sr[38:0], 1'b0};
            r_tx_crc <= {r_tx_crc[5:3], r_tx_crc[2] ^ w_tx_fb, r_tx_crc[1:0], w_tx_fb};
          end else if (r_bcnt < 6'd47) begin
            r_out    <= r_tx_crc[6];
            r_tx_crc <= {r_tx_crc[5:0], 1'b0};
          end else if (r_bcnt == 6'd47) begin
            r_out    <= 1'b1;
          end else begin
            r_oe <= 1'b0;
            if (r_type == 2'b00) begin
              r_gcnt  <= GW'(NRC);
              r_state <= S_GAP;
            end else begin
              r_wcnt  <= WW'(1);
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if ((r_wcnt >= WW'(2)) && !w_line) begin
            r_rcnt   <= 8'd1;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            r_rx_crc <= '0;
`endif
            r_state  <= S_RECV;
          end else if (r_wcnt == WW'(NCR_MAX)) begin
            r_timeout <= 1'b1;
            r_gcnt    <= GW'(NRC);
            r_state   <= S_GAP;
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
          end
        end

        S_RECV: begin
          r_rx_sr <= {r_rx_sr[125:0], w_line};
          r_rcnt  <= r_rcnt + 8'd1;
          if (r_rcnt == 8'd1) begin
            r_rx_tbit <= w_line;
          end
`ifdef SD_CMD_RESP_CRC_CHECK_EN
          if (w_crc_feed) begin
            r_rx_crc <= {r_rx_crc[5:3], r_rx_crc[2] ^ w_rx_fb, r_rx_crc[1:0], w_rx_fb};
          end
`endif
          if (w_final) begin
            r_resp      <= w_long ? r_rx_sr[126:7] : {82'b0, r_rx_sr[44:7]};
            r_frame_err <= w_frame_bad;
`ifdef SD_CMD_RESP_CRC_CHECK_EN
            r_crc_err   <= w_crc_bad;
`endif
            // The card still owns the end bit for the cycle after it is sampled,
            // so the gap after a response is one cycle longer.
            r_gcnt      <= GW'(NRC + 1);
            r_state     <= S_GAP;
          end
        end

        S_GAP: begin
          if (r_gcnt <= GW'(1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_gcnt <= r_gcnt - GW'(1);
          end
        end

        S_DONE: begin
          if (!istart) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Parametrised SD CMD-line engine: serialises a 48-bit command frame with on-the-fly CRC7, releases the line, and captures a none/short/long response. It adds response-type selection, start-bit timeout, index/end-bit/CRC checking and a post-response gap. It sits between the SD host controller FSM and the bidirectional CMD pad, clocked by the SD clock.

## Interface
- NCR_MAX, 64: max cycles after line release to wait for the response start bit before timeout (≥2).
- NRC, 8: idle cycles the line stays released after the response (or after the command for type 00) before odone.
- iclk  in  1  SD clock; all logic on rising edge.
- irst  in  1  reset: one clock; reset is synchronous and active-high.
- iocmd_sd  inout  1  CMD line; driven only in SEND, otherwise 'z'.
- istart  in  1  level request; launches a command when high in IDLE.
- icmd_index  in  6  command index; sampled at launch.
- icmd_arg  in  32  argument; sampled at launch.
- iresp_type  in  2  00 none, 01 short+CRC (R1/R6/R7), 10 short no CRC (R3), 11 long (R2); sampled at launch.
- oresp  out  120  captured payload; type 01/10: {82'b0, bits[45:8]}; type 11: bits[127:8] of 136-bit frame; zero for 00.
- odone  out  1  high in DONE.
- otimeout  out  1  no start bit within NCR_MAX.
- ocrc_err  out  1  response CRC7 mismatch.
- oframe_err  out  1  end bit ≠1, transmission bit ≠0, or (type 01) index ≠ icmd_index.

## Operation
- Command frame, MSB first: '0', '1', index[5:0], arg[31:0], CRC7[6:0], '1'. CRC7 polynomial x^7+x^3+1, init 0, over the first 40 bits.
- States: IDLE → SEND (48 bits) → type 00: GAP; else WAIT → RECV → GAP → DONE → IDLE.
- IDLE: line 'z', inputs latched when istart=1; status outputs cleared at launch.
- WAIT: counter from 0 at release; line sampled each cycle from count 2; '0' sampled → RECV; count reaches NCR_MAX → otimeout=1, go to GAP.
- RECV: shift remaining 47 (short) or 135 (long) bits into shift register; receive CRC7 runs on bits 47..8 (short) or on bits 127..8 of the long frame, compared with bits 7..1.
- Type 10 skips CRC; type 11 skips index check (reserved bits 133..128 ignored).
- GAP: NRC cycles released, then DONE.
- DONE: odone=1, status and oresp held; leaves to IDLE only when istart=0 (holding istart high never relaunches).
- irst (any state): next edge → IDLE, line 'z', all outputs 0.

## Timing
- Reset values: odone=0, otimeout=0, ocrc_err=0, oframe_err=0, oresp=0, iocmd_sd='z'.
- istart sampled high in IDLE at edge k: start bit driven from edge k+1; bit n on line from edge k+1+n; end bit from edge k+48; released at edge k+49.
- Response start bit sampled at edge s: final response bit sampled at edge s+47 (short) or s+135 (long); oresp/status updated on the same edge; odone rises at edge s+47+NRC+1 (short).
- Timeout: otimeout and entry to GAP at edge k+49+NCR_MAX.
- Type 00: odone at edge k+49+NRC.
- Line activity during SEND is ignored (no collision detect).

## Configuration
- SD_CMD_RESP_CRC_CHECK_EN defined: receive CRC7 generator and comparator present; ocrc_err as specified.
- Undefined: receive CRC logic omitted, ocrc_err tied 0; frame checks and transmit CRC unaffected.

## Test plan
- CMD17 (0x11), arg 0, type 01 -> line carries 0,1,010001,32×0,0101010,1; card returns 0,0,010001,0x00000900,0110011,1 -> odone=1, oresp={82'b0,6'h11,32'h00000900}, all errors 0.
- CMD0, arg 0, type 00 -> CRC bits 1001010, no capture, odone exactly NRC cycles after release, oresp=0.
- CMD17, type 01, no card drive (pull-up) -> otimeout=1 at NCR_MAX cycles after release, odone after NRC more.
- Same as test 1 with CRC bit 0 flipped -> ocrc_err=1 (0 with macro undefined); index 0x12 returned -> oframe_err=1.
- CMD2 type 11, card returns 136-bit R2 with CID 0x0123…EF+valid CRC -> oresp = CID[127:8], errors 0; istart held high -> stays in DONE, no relaunch until istart drops.
- irst asserted at bit 20 of SEND -> line 'z' next cycle, outputs 0; new istart launches a clean frame.
